// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the fetch/decode/execute sequencer and the CPU datapath.
// master = sequencer side, slave = datapath/memory side.
interface ctrl_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] instr;
  logic              zero;
  logic              mem_ready;
  logic              mem_req;
  logic              mem_we;
  logic              pc_en;
  logic              pc_sel;
  logic              ir_en;
  logic              mar_en;
  logic              acc_en;
  logic [1:0]        alu_op;
  logic              halted;
  logic              illegal;
  logic [2:0]        state;

  modport master (
    input  start, instr, zero, mem_ready,
    output mem_req, mem_we, pc_en, pc_sel, ir_en, mar_en, acc_en,
           alu_op, halted, illegal, state
  );

  modport slave (
    output start, instr, zero, mem_ready,
    input  mem_req, mem_we, pc_en, pc_sel, ir_en, mar_en, acc_en,
           alu_op, halted, illegal, state
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM driving the datapath register
// enables, the memory request handshake and the ALU operation select.
module ctrl_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_t     cur;
  logic       illegal_q;
  logic [3:0] opcode;

  assign opcode = bus.instr[DATA_W-1 -: 4];

  function automatic logic op_defined(input logic [3:0] op);
    return (op <= OP_JZ) || (op == OP_HLT);
  endfunction

  // Opcodes whose EXEC phase is a memory transaction and waits on mem_ready.
  function automatic logic op_mem(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      case (cur)
        IDLE:   if (bus.start) cur <= FETCH;
        FETCH:  if (bus.mem_ready) cur <= DECODE;
        DECODE: begin
          if (!op_defined(opcode)) begin
            illegal_q <= 1'b1;
            cur       <= FETCH;
          end else if (opcode == OP_HLT) begin
            cur <= HALT;
          end else if (opcode == OP_NOP) begin
            cur <= FETCH;
          end else begin
            cur <= EXEC;
          end
        end
        EXEC:   if (!op_mem(opcode) || bus.mem_ready) cur <= FETCH;
        HALT:   cur <= HALT;
        default: cur <= IDLE;
      endcase
    end
  end

  // Enables are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.pc_en   = 1'b0;
    bus.pc_sel  = 1'b0;
    bus.ir_en   = 1'b0;
    bus.mar_en  = 1'b0;
    bus.acc_en  = 1'b0;
    bus.alu_op  = 2'd0;
    bus.halted  = 1'b0;
    case (cur)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_en   = bus.mem_ready;
        bus.pc_en   = bus.mem_ready;
      end
      DECODE: bus.mar_en = op_mem(opcode);
      EXEC: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB: begin
            bus.mem_req = 1'b1;
            bus.acc_en  = bus.mem_ready;
            bus.alu_op  = (opcode == OP_ADD) ? 2'd1 : (opcode == OP_SUB) ? 2'd2 : 2'd0;
          end
          OP_STORE: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = 1'b1;
          end
          OP_JMP: begin
            bus.pc_en  = 1'b1;
            bus.pc_sel = 1'b1;
          end
          OP_JZ: begin
            bus.pc_en  = bus.zero;
            bus.pc_sel = bus.zero;
          end
          default: ;
        endcase
      end
      HALT:    bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.state   = cur;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed vector bench for ctrl_sequencer: each record is one clock cycle of
// inputs plus the outputs expected before the next rising edge.
module tb_ctrl_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ctrl_sequencer_if #(.DATA_W(8)) bus ();

  ctrl_sequencer #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       pce;
    logic       pcs;
    logic       ire;
    logic       mare;
    logic       acce;
    logic [1:0] alu;
    logic       hlt;
    logic       ill;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] instr;
    logic       zero;
    logic       rdy;
    outs_t      exp;
    string      name;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  function automatic outs_t o(input logic [2:0] st, input logic req, input logic we,
                              input logic pce, input logic pcs, input logic ire,
                              input logic mare, input logic acce, input logic [1:0] alu,
                              input logic hlt, input logic ill);
    outs_t r;
    r.st = st; r.req = req; r.we = we; r.pce = pce; r.pcs = pcs; r.ire = ire;
    r.mare = mare; r.acce = acce; r.alu = alu; r.hlt = hlt; r.ill = ill;
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] ins,
                              input logic z, input logic rdy, input outs_t e, input string n);
    vec_t v;
    v.rst = r; v.start = s; v.instr = ins; v.zero = z; v.rdy = rdy; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic outs_t sample();
    outs_t r;
    r.st = bus.state; r.req = bus.mem_req; r.we = bus.mem_we; r.pce = bus.pc_en;
    r.pcs = bus.pc_sel; r.ire = bus.ir_en; r.mare = bus.mar_en; r.acce = bus.acc_en;
    r.alu = bus.alu_op; r.hlt = bus.halted; r.ill = bus.illegal;
    return r;
  endfunction

  // Inputs change on the falling edge, outputs are checked 1 ns later.
  task automatic apply_check(input vec_t v);
    outs_t got;
    @(negedge clk);
    rst           = v.rst;
    bus.start     = v.start;
    bus.instr     = v.instr;
    bus.zero      = v.zero;
    bus.mem_ready = v.rdy;
    #1;
    got = sample();
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s: got st=%0d req=%b we=%b pce=%b pcs=%b ire=%b mare=%b acce=%b alu=%0d hlt=%b ill=%b, exp st=%0d req=%b we=%b pce=%b pcs=%b ire=%b mare=%b acce=%b alu=%0d hlt=%b ill=%b",
               v.name, got.st, got.req, got.we, got.pce, got.pcs, got.ire, got.mare,
               got.acce, got.alu, got.hlt, got.ill, v.exp.st, v.exp.req, v.exp.we,
               v.exp.pce, v.exp.pcs, v.exp.ire, v.exp.mare, v.exp.acce, v.exp.alu,
               v.exp.hlt, v.exp.ill);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.instr     = 8'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    //            rst start instr zero rdy   st req we pce pcs ire mar acc alu hlt ill
    vq.push_back(mk(1, 0, 8'h00, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset"));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_no_start"));
    vq.push_back(mk(0, 1, 8'h00, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_start"));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "nop_fetch1"));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "nop_decode1"));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "nop_fetch2"));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "nop_decode2"));
    vq.push_back(mk(0, 0, 8'h1A, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "load_fetch"));
    vq.push_back(mk(0, 0, 8'h1A, 0, 1, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "load_decode"));
    vq.push_back(mk(0, 0, 8'h1A, 0, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "load_wait1"));
    vq.push_back(mk(0, 0, 8'h1A, 0, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "load_wait2"));
    vq.push_back(mk(0, 0, 8'h1A, 0, 1, o(3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), "load_done"));
    vq.push_back(mk(0, 1, 8'h30, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait"));
    vq.push_back(mk(0, 0, 8'h30, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "add_fetch"));
    vq.push_back(mk(0, 0, 8'h30, 0, 1, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "add_decode"));
    vq.push_back(mk(0, 0, 8'h30, 0, 1, o(3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0), "add_exec"));
    vq.push_back(mk(0, 0, 8'h40, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "sub_fetch"));
    vq.push_back(mk(0, 0, 8'h40, 0, 1, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "sub_decode"));
    vq.push_back(mk(0, 0, 8'h40, 0, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0), "sub_wait"));
    vq.push_back(mk(0, 0, 8'h40, 0, 1, o(3, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0), "sub_done"));
    vq.push_back(mk(0, 0, 8'h20, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "store_fetch"));
    vq.push_back(mk(0, 0, 8'h20, 0, 1, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "store_decode"));
    vq.push_back(mk(0, 0, 8'h20, 0, 1, o(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "store_exec"));
    vq.push_back(mk(0, 0, 8'h50, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "jmp_fetch"));
    vq.push_back(mk(0, 0, 8'h50, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "jmp_decode"));
    vq.push_back(mk(0, 0, 8'h50, 0, 0, o(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "jmp_exec"));
    vq.push_back(mk(0, 0, 8'h60, 1, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "jz1_fetch"));
    vq.push_back(mk(0, 0, 8'h60, 1, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "jz1_decode"));
    vq.push_back(mk(0, 0, 8'h60, 1, 1, o(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "jz_taken"));
    vq.push_back(mk(0, 0, 8'h60, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "jz0_fetch"));
    vq.push_back(mk(0, 0, 8'h60, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "jz0_decode"));
    vq.push_back(mk(0, 0, 8'h60, 0, 1, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "jz_not_taken"));
    vq.push_back(mk(0, 0, 8'h90, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "ill_fetch"));
    vq.push_back(mk(0, 0, 8'h90, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_decode"));
    vq.push_back(mk(0, 0, 8'hF0, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1), "ill_sticky_fetch"));
    vq.push_back(mk(0, 0, 8'hF0, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "hlt_decode"));
    vq.push_back(mk(0, 1, 8'hF0, 0, 1, o(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "halt_start"));
    vq.push_back(mk(0, 0, 8'hF0, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "halt_hold"));
    vq.push_back(mk(0, 1, 8'h00, 0, 1, o(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "halt_ignore"));

    foreach (vq[i]) apply_check(vq[i]);

    // Reset during a stalled fetch with illegal already set.
    apply_check(mk(1, 0, 8'h00, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_from_halt"));
    apply_check(mk(0, 1, 8'h90, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seq2_start"));
    apply_check(mk(0, 0, 8'h90, 0, 1, o(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "seq2_fetch"));
    apply_check(mk(0, 0, 8'h90, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seq2_decode_ill"));
    apply_check(mk(0, 0, 8'h90, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "seq2_fetch_wait"));
    apply_check(mk(1, 0, 8'h90, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_mid_fetch"));
    apply_check(mk(0, 0, 8'h90, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle1"));
    apply_check(mk(0, 0, 8'h90, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle2"));
    apply_check(mk(0, 1, 8'h00, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_start"));
    apply_check(mk(0, 0, 8'h00, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_fetch"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle fetch/decode/execute control FSM for the CPU datapath. It drives the load-enable inputs of the datapath's enabled registers (PC, IR, MAR, ACC), the memory request handshake and the ALU operation select. It consumes the instruction word held in IR and the accumulator zero flag. It sits directly upstream of the enable-controlled register bank: every `*_en` output connects straight to a register's `en` input.

## Interface
- n, default 8, instruction/data width in bits; opcode is `instr[n-1:n-4]`, so n >= 4.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin execution from IDLE; level-sampled, ignored outside IDLE.
- instr  input  n  current IR contents.
- zero  input  1  accumulator-equals-zero flag from the datapath.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access requested.
- mem_we  output  1  write strobe; valid only with mem_req.
- pc_en  output  1  PC register load enable.
- pc_sel  output  1  PC source: 0 = PC+1, 1 = operand/jump target.
- ir_en  output  1  IR register load enable.
- mar_en  output  1  MAR register load enable.
- acc_en  output  1  ACC register load enable.
- alu_op  output  2  ALU op: 0 = pass B, 1 = add, 2 = sub, 3 = reserved.
- halted  output  1  in HALT state.
- illegal  output  1  sticky flag: an undefined opcode was decoded.
- state  output  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, HALT = 4. Codes 5–7 are unreachable; if entered, go to IDLE.
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 JMP, 6 JZ, F HLT. All other opcodes behave as NOP and set `illegal`.
- **IDLE**
  - All enables 0.
  - `start` = 1 -> FETCH.
- **FETCH**
  - `mem_req` = 1, `mem_we` = 0.
  - While `mem_ready` = 0: hold, all enables 0.
  - In the cycle `mem_ready` = 1: `ir_en` = 1, `pc_en` = 1, `pc_sel` = 0, then -> DECODE.
- **DECODE** (exactly one cycle)
  - `mar_en` = 1 for LOAD, STORE, ADD, SUB.
  - NOP or illegal opcode -> FETCH.
  - HLT -> HALT.
  - All other opcodes -> EXEC.
- **EXEC, LOAD/ADD/SUB**
  - `mem_req` = 1, `mem_we` = 0.
  - `alu_op` = 0, 1 or 2 respectively, held for the whole state.
  - On `mem_ready`: `acc_en` = 1, then -> FETCH.
- **EXEC, STORE**
  - `mem_req` = 1, `mem_we` = 1.
  - On `mem_ready` -> FETCH. No register enable is asserted.
- **EXEC, JMP** (one cycle)
  - `pc_en` = 1, `pc_sel` = 1, then -> FETCH.
- **EXEC, JZ** (one cycle)
  - `zero` is sampled in this cycle.
  - If 1: `pc_en` = 1, `pc_sel` = 1.
  - If 0: no enable.
  - Either way -> FETCH.
- **HALT**
  - All enables and `mem_req` = 0, `halted` = 1.
  - Only `rst` leaves HALT. `start` is ignored.
- Output decoding:
  - Enables are combinational from state, `instr` and `mem_ready`.
  - Each enable is a single-cycle pulse per handshake completion.
  - At most one of `ir_en`, `mar_en`, `acc_en` is high in any cycle.
- `illegal` is registered. It is set on the DECODE edge of an undefined opcode and cleared only by `rst`.

## Timing
- Reset: state = IDLE and `illegal` = 0, asynchronously and immediately. All outputs 0, `alu_op` = 0, `state` = 0.
- Reset mid-handshake: `mem_req` and all enables drop in the same cycle `rst` rises. No partial load occurs.
- `start` to first `mem_req`: 1 cycle; FETCH is entered on the edge after `start` is sampled.
- Cycle counts, with `mem_ready` tied high:
  - NOP: 2 cycles.
  - JMP, JZ: 3 cycles.
  - LOAD, ADD, SUB, STORE: 3 cycles.
  - Each wait cycle with `mem_ready` = 0 adds 1 cycle to FETCH or EXEC.
- `mem_ready` outside FETCH or memory-type EXEC: ignored.
- `instr` must be stable from DECODE through EXEC. IR is written only in FETCH, so the datapath guarantees this.

## Test plan
- Reset then `start` = 1 for one cycle, `mem_ready` = 1, instr = 0x00 (NOP):
  - state sequence 0, 1, 2, 1, 2…
  - `ir_en` and `pc_en` pulse every 2 cycles.
- instr = 0x1A (LOAD), `mem_ready` low for 2 cycles in EXEC:
  - `mar_en` in DECODE.
  - `mem_req` held for 3 EXEC cycles.
  - `acc_en` = 1 with `alu_op` = 0 only in the `mem_ready` cycle.
- instr = 0x60 (JZ):
  - `zero` = 1: `pc_en` = 1, `pc_sel` = 1 in EXEC.
  - `zero` = 0: no `pc_en` in EXEC, next state FETCH.
- instr = 0x20 (STORE): `mem_req` = 1 and `mem_we` = 1 in EXEC; `acc_en`, `pc_en` and `ir_en` all 0.
- instr = 0x90 (illegal), then 0xF0 (HLT):
  - `illegal` goes 1 after the first DECODE and stays 1.
  - `halted` = 1, state = 4.
  - `start` and `mem_ready` pulses produce no change.
- Assert `rst` during FETCH wait with `mem_req` = 1:
  - `mem_req` = 0 in the same cycle, state = 0, `illegal` = 0.
  - After release, nothing happens until `start`.
